// File: rtl/full_calc_ctrl_if.sv
// Handshake bundle between the full-calculator controller and its datapath.
// FULLCALC_DIV0_CHK_EN adds the y_zero divisor flag.
interface full_calc_ctrl_if;
    logic       go;
    logic [2:0] qF;
    logic       Done_Calc;
    logic       Done_DIV;
`ifdef FULLCALC_DIV0_CHK_EN
    logic       y_zero;
`endif
    logic       En_F;
    logic       En_X;
    logic       En_Y;
    logic       Go_Calc;
    logic       Go_DIV;
    logic [1:0] Op_Calc;
    logic [1:0] Sel_L;
    logic       Sel_H;
    logic       En_out_L;
    logic       En_out_H;
    logic       busy;
    logic       done;
    logic       err;

    // Controller side
    modport slave (
`ifdef FULLCALC_DIV0_CHK_EN
        input  y_zero,
`endif
        input  go, qF, Done_Calc, Done_DIV,
        output En_F, En_X, En_Y, Go_Calc, Go_DIV, Op_Calc, Sel_L, Sel_H,
               En_out_L, En_out_H, busy, done, err
    );

    // Datapath / requester side
    modport master (
`ifdef FULLCALC_DIV0_CHK_EN
        output y_zero,
`endif
        output go, qF, Done_Calc, Done_DIV,
        input  En_F, En_X, En_Y, Go_Calc, Go_DIV, Op_Calc, Sel_L, Sel_H,
               En_out_L, En_out_H, busy, done, err
    );
endinterface

// File: rtl/full_calc_ctrl.sv
// Control FSM for the full-calculator datapath: load, decode, run Calc/MUL/DIV, write back.
// Optional divide-by-zero trap when FULLCALC_DIV0_CHK_EN is defined.
module full_calc_ctrl #(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned TIMEOUT = 32
) (
    input logic             clk,
    input logic             rst,
    full_calc_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_CALC     = 4'd3;
    localparam logic [3:0] S_WR_CALC  = 4'd4;
    localparam logic [3:0] S_MUL_WAIT = 4'd5;
    localparam logic [3:0] S_WR_MUL   = 4'd6;
    localparam logic [3:0] S_DIV_GO   = 4'd7;
    localparam logic [3:0] S_DIV_WAIT = 4'd8;
    localparam logic [3:0] S_WR_DIV   = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;
    localparam logic [3:0] S_ERR      = 4'd11;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_ld_q, en_ld_d;
    logic             go_calc_q, go_calc_d;
    logic             go_div_q, go_div_d;
    logic [1:0]       sel_l_q, sel_l_d;
    logic             sel_h_q, sel_h_d;
    logic             en_l_q, en_l_d;
    logic             en_h_q, en_h_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             div_trap;

`ifdef FULLCALC_DIV0_CHK_EN
    assign div_trap = bus.y_zero;
`else
    assign div_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            en_ld_q   <= 1'b0;
            go_calc_q <= 1'b0;
            go_div_q  <= 1'b0;
            sel_l_q   <= 2'b00;
            sel_h_q   <= 1'b0;
            en_l_q    <= 1'b0;
            en_h_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_ld_q   <= en_ld_d;
            go_calc_q <= go_calc_d;
            go_div_q  <= go_div_d;
            sel_l_q   <= sel_l_d;
            sel_h_q   <= sel_h_d;
            en_l_q    <= en_l_d;
            en_h_q    <= en_h_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state and wait counter; a done on the timeout cycle takes the write path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (bus.go) state_d = S_LOAD;
            S_LOAD:   state_d = S_DECODE;
            S_DECODE: begin
                cnt_d = '0;
                if (!bus.qF[2])          state_d = S_CALC;
                else if (bus.qF == 3'b100) state_d = (MUL_LAT == 0) ? S_WR_MUL : S_MUL_WAIT;
                else if (bus.qF == 3'b101) state_d = div_trap ? S_ERR : S_DIV_GO;
                else                     state_d = S_ERR;
            end
            S_CALC: begin
                if (bus.Done_Calc)       state_d = S_WR_CALC;
                else if (cnt_q == TO_LAST) state_d = S_ERR;
                if (cnt_q != CNT_MAX)    cnt_d = cnt_q + CNT_W'(1);
            end
            S_WR_CALC: state_d = S_DONE;
            S_MUL_WAIT: begin
                if (cnt_q == MUL_LAST)   state_d = S_WR_MUL;
                if (cnt_q != CNT_MAX)    cnt_d = cnt_q + CNT_W'(1);
            end
            S_WR_MUL: state_d = S_DONE;
            S_DIV_GO: begin
                state_d = S_DIV_WAIT;
                cnt_d   = '0;
            end
            S_DIV_WAIT: begin
                if (bus.Done_DIV)        state_d = S_WR_DIV;
                else if (cnt_q == TO_LAST) state_d = S_ERR;
                if (cnt_q != CNT_MAX)    cnt_d = cnt_q + CNT_W'(1);
            end
            S_WR_DIV: state_d = S_DONE;
            S_DONE:   if (!bus.go) state_d = S_IDLE;
            S_ERR:    if (!bus.go) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register in step with it.
    always_comb begin
        en_ld_d   = 1'b0;
        go_calc_d = 1'b0;
        go_div_d  = 1'b0;
        sel_l_d   = 2'b00;
        sel_h_d   = 1'b0;
        en_l_d    = 1'b0;
        en_h_d    = 1'b0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        case (state_d)
            S_LOAD:    en_ld_d   = 1'b1;
            S_CALC:    go_calc_d = 1'b1;
            S_DIV_GO:  go_div_d  = 1'b1;
            S_WR_CALC: begin
                sel_l_d = 2'b01;
                en_l_d  = 1'b1;
            end
            S_WR_MUL: begin
                sel_l_d = 2'b10;
                en_l_d  = 1'b1;
                en_h_d  = 1'b1;
            end
            S_WR_DIV: begin
                sel_l_d = 2'b11;
                sel_h_d = 1'b1;
                en_l_d  = 1'b1;
                en_h_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.En_F     = en_ld_q;
    assign bus.En_X     = en_ld_q;
    assign bus.En_Y     = en_ld_q;
    assign bus.Go_Calc  = go_calc_q;
    assign bus.Go_DIV   = go_div_q;
    assign bus.Op_Calc  = bus.qF[1:0];
    assign bus.Sel_L    = sel_l_q;
    assign bus.Sel_H    = sel_h_q;
    assign bus.En_out_L = en_l_q;
    assign bus.En_out_H = en_h_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_full_calc_ctrl.sv
// Self-checking bench for full_calc_ctrl: vector table with a write-back scoreboard,
// plus hand sequences for reset during DIV_WAIT and go held through DONE.
module tb_full_calc_ctrl;
    localparam int MUL_LAT = 1;
    localparam int TIMEOUT = 32;

    logic clk;
    logic rst;
    full_calc_ctrl_if bus();

    full_calc_ctrl #(.MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] qf;
        logic       yz;
        int         dly;       // engine-done delay after Go seen; -1 = never
        int         lat;       // posedges from go sample to done/err
        logic       exp_err;
        logic [1:0] sel_l;
        logic       sel_h;
        logic       en_h;
        int         go_div;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] qf, input logic yz,
                                input int dly, input int lat, input logic e,
                                input logic [1:0] sl, input logic sh, input logic eh,
                                input int gd);
        vec_t v;
        v.name = nm; v.qf = qf; v.yz = yz; v.dly = dly; v.lat = lat; v.exp_err = e;
        v.sel_l = sl; v.sel_h = sh; v.en_h = eh; v.go_div = gd;
        return v;
    endfunction

    task automatic drive_inputs(input logic [2:0] qf, input logic yz, input logic go);
        bus.qF = qf;
        bus.go = go;
`ifdef FULLCALC_DIV0_CHK_EN
        bus.y_zero = yz;
`else
        if (yz) bus.Done_Calc = 1'b0;
`endif
    endtask

    task automatic run_txn(input vec_t v);
        int edges = 0, first = -1, en_f = 0, go_div = 0, en_l = 0, op_bad = 0, ld_bad = 0;
        bit fin = 0;
        vec_t e;
        @(negedge clk);
        drive_inputs(v.qf, v.yz, 1'b1);
        exp_q.push_back(v);
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            edges++;
            bus.Done_Calc = 1'b0;
            bus.Done_DIV  = 1'b0;
            if (first < 0 && (bus.Go_Calc || bus.Go_DIV)) first = edges;
            if (v.dly >= 0 && first >= 0 && edges == first + v.dly) begin
                if (v.qf[2]) bus.Done_DIV = 1'b1;
                else         bus.Done_Calc = 1'b1;
            end
            en_f   += int'(bus.En_F);
            go_div += int'(bus.Go_DIV);
            en_l   += int'(bus.En_out_L);
            if (bus.En_X != bus.En_F || bus.En_Y != bus.En_F) ld_bad++;
            if (bus.Go_Calc && bus.Op_Calc != v.qf[1:0]) op_bad++;
            if (bus.En_out_L) begin
                if (exp_q.size() == 0) check({v.name, " unexpected write"}, 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check({e.name, " Sel_L"}, int'(bus.Sel_L), int'(e.sel_l));
                    check({e.name, " Sel_H"}, int'(bus.Sel_H), int'(e.sel_h));
                    check({e.name, " En_out_H"}, int'(bus.En_out_H), int'(e.en_h));
                end
            end
            if (bus.done || bus.err) fin = 1;
        end
        bus.Done_Calc = 1'b0;
        bus.Done_DIV  = 1'b0;
        check({v.name, " finished in bound"}, int'(fin), 1);
        check({v.name, " latency"}, edges, v.lat);
        check({v.name, " err"}, int'(bus.err), int'(v.exp_err));
        check({v.name, " done"}, int'(bus.done), int'(!v.exp_err));
        check({v.name, " load pulses"}, en_f, 1);
        check({v.name, " load enables aligned"}, ld_bad, 0);
        check({v.name, " Go_DIV cycles"}, go_div, v.go_div);
        check({v.name, " write pulses"}, en_l, v.exp_err ? 0 : 1);
        check({v.name, " Op_Calc"}, op_bad, 0);
        if (v.exp_err && exp_q.size() > 0) void'(exp_q.pop_front());
        check({v.name, " scoreboard drained"}, exp_q.size(), 0);
        bus.go = 1'b0;
        @(negedge clk);
        check({v.name, " back to idle"}, int'({bus.busy, bus.done, bus.err}), 0);
    endtask

    function automatic int all_outs();
        return int'({bus.En_F, bus.En_X, bus.En_Y, bus.Go_Calc, bus.Go_DIV, bus.Sel_L,
                     bus.Sel_H, bus.En_out_L, bus.En_out_H, bus.busy, bus.done, bus.err});
    endfunction

    initial begin
        int cnt;
        rst = 1'b0;
        bus.Done_Calc = 1'b0;
        bus.Done_DIV  = 1'b0;
        drive_inputs(3'b000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset outputs", all_outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle after reset", all_outs(), 0);

        // Calc latency 5+d, mul 4+MUL_LAT, div 5+d (d>=1), invalid 3, timeouts 3/4+TIMEOUT.
        vecs.push_back(mk("add",      3'b000, 0, 1,  6, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk("sub",      3'b001, 0, 0,  5, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk("and",      3'b010, 0, 4,  9, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk("xor",      3'b011, 0, 2,  7, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk("mul",      3'b100, 0, -1, 4 + MUL_LAT, 0, 2'b10, 0, 1, 0));
        vecs.push_back(mk("div",      3'b101, 0, 10, 15, 0, 2'b11, 1, 1, 1));
        vecs.push_back(mk("div_fast", 3'b101, 0, 1,  6, 0, 2'b11, 1, 1, 1));
        vecs.push_back(mk("inv110",   3'b110, 0, -1, 3, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk("inv111",   3'b111, 0, -1, 3, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk("calc_to",  3'b000, 0, -1, 3 + TIMEOUT, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk("div_to",   3'b101, 0, -1, 4 + TIMEOUT, 1, 2'b00, 0, 0, 1));
        vecs.push_back(mk("calc_race", 3'b011, 0, TIMEOUT - 1, 4 + TIMEOUT, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk("div_race", 3'b101, 0, TIMEOUT, 5 + TIMEOUT, 0, 2'b11, 1, 1, 1));
`ifdef FULLCALC_DIV0_CHK_EN
        vecs.push_back(mk("div0",     3'b101, 1, 1, 3, 1, 2'b00, 0, 0, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        // Reset asserted mid-divide clears outputs without waiting for a clock edge.
        @(negedge clk);
        drive_inputs(3'b101, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("busy before reset", int'(bus.busy), 1);
        #2 rst = 1'b0;
        #1 check("async reset outputs", all_outs(), 0);
        bus.go = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle after mid-op reset", all_outs(), 0);

        // go held high through DONE must not reload.
        @(negedge clk);
        drive_inputs(3'b100, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt += int'(bus.En_F);
        end
        check("done held while go high", int'(bus.done), 1);
        check("single load with go held", cnt, 1);
        bus.go = 1'b0;
        @(negedge clk);
        check("idle after go drop", int'(bus.busy), 0);
        @(negedge clk);
        check("no restart after go drop", int'(bus.En_F), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
